// File: rtl/ic_align_pkg.sv
// ic_align_pkg: shared types, constants and halfword classification for the RV32IC fetch aligner
package ic_align_pkg;
  typedef enum logic [1:0] {EMPTY, SKIP_LO, HAVE_C, HAVE_LO32} state_e;
  localparam logic [15:0] RVC_ILLEGAL = 16'h0000;
  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/ic_align_if.sv
// ic_align_if: fetch-side and decode-side signals of the instruction aligner
// master: IFetch/ID side (drives flush, fetch word, id_stall; sees stall and aligned output)
// slave : aligner side
// out_illegal exists only when IC_ALIGN_ILLEGAL_EN is defined
interface ic_align_if #(parameter int XLEN = 32);
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fetch_instr;
  logic            fetch_stall;
  logic            id_stall;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_compressed;
`ifdef IC_ALIGN_ILLEGAL_EN
  logic            out_illegal;
  modport master (output flush, flush_pc, fetch_valid, fetch_pc, fetch_instr, id_stall,
                  input fetch_stall, out_valid, out_pc, out_instr, out_compressed, out_illegal);
  modport slave  (input flush, flush_pc, fetch_valid, fetch_pc, fetch_instr, id_stall,
                  output fetch_stall, out_valid, out_pc, out_instr, out_compressed, out_illegal);
`else
  modport master (output flush, flush_pc, fetch_valid, fetch_pc, fetch_instr, id_stall,
                  input fetch_stall, out_valid, out_pc, out_instr, out_compressed);
  modport slave  (input flush, flush_pc, fetch_valid, fetch_pc, fetch_instr, id_stall,
                  output fetch_stall, out_valid, out_pc, out_instr, out_compressed);
`endif
endinterface

// File: rtl/ic_align.sv
// ic_align: splits word-aligned fetch words into aligned 16/32-bit instructions for ID
// Ports: clk, reset (async, active-high), bus (ic_align_if.slave: flush/redirect,
// fetch word in, fetch_stall out, id_stall in, registered aligned instruction out).
// Optional IC_ALIGN_ILLEGAL_EN adds out_illegal flagging the all-zero compressed encoding.
module ic_align
  import ic_align_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       reset,
  ic_align_if.slave bus
);
  state_e          state_q, state_d;
  logic [15:0]     buf_q, buf_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d, pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d, c_q, c_d;
  logic [15:0]     lo, hi;
  logic [XLEN-1:0] pc2;
  logic            consume;
  assign lo = bus.fetch_instr[15:0];
  assign hi = bus.fetch_instr[31:16];
  assign pc2 = bus.fetch_pc + XLEN'(2);
  // HAVE_C drains the buffered halfword, so the presented word must be held for a cycle
  assign bus.fetch_stall = !bus.flush && (bus.id_stall || state_q == HAVE_C);
  assign consume = bus.fetch_valid && !bus.fetch_stall && !bus.flush;
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    buf_pc_d = buf_pc_q;
    valid_d = valid_q;
    pc_d = pc_q;
    instr_d = instr_q;
    c_d = c_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      buf_d = '0;
      buf_pc_d = bus.flush_pc & ~XLEN'(1);
      state_d = bus.flush_pc[1] ? SKIP_LO : EMPTY;
    end else if (!bus.id_stall) begin
      valid_d = 1'b0;
      case (state_q)
        EMPTY: if (consume) begin
          valid_d = 1'b1;
          pc_d = bus.fetch_pc;
          c_d = is_rvc(lo);
          instr_d = is_rvc(lo) ? {16'h0, lo} : bus.fetch_instr;
          if (is_rvc(lo)) begin
            buf_d = hi;
            buf_pc_d = pc2;
            state_d = is_rvc(hi) ? HAVE_C : HAVE_LO32;
          end
        end
        SKIP_LO: if (consume) begin
          if (is_rvc(hi)) begin
            valid_d = 1'b1;
            pc_d = pc2;
            instr_d = {16'h0, hi};
            c_d = 1'b1;
            state_d = EMPTY;
          end else begin
            buf_d = hi;
            buf_pc_d = pc2;
            state_d = HAVE_LO32;
          end
        end
        HAVE_C: begin
          valid_d = 1'b1;
          pc_d = buf_pc_q;
          instr_d = {16'h0, buf_q};
          c_d = 1'b1;
          state_d = EMPTY;
        end
        HAVE_LO32: if (consume) begin
          valid_d = 1'b1;
          pc_d = buf_pc_q;
          instr_d = {lo, buf_q};
          c_d = 1'b0;
          buf_d = hi;
          buf_pc_d = pc2;
          state_d = is_rvc(hi) ? HAVE_C : HAVE_LO32;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      buf_q <= '0;
      buf_pc_q <= '0;
      valid_q <= 1'b0;
      pc_q <= RESET_PC;
      instr_q <= '0;
      c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      buf_pc_q <= buf_pc_d;
      valid_q <= valid_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      c_q <= c_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_pc = pc_q;
  assign bus.out_instr = instr_q;
  assign bus.out_compressed = c_q;
`ifdef IC_ALIGN_ILLEGAL_EN
  logic ill_q, ill_d;
  assign ill_d = valid_d && c_d && instr_d[15:0] == RVC_ILLEGAL;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ill_q <= 1'b0;
    else ill_q <= ill_d;
  end
  assign bus.out_illegal = ill_q;
`endif
endmodule

// File: doc/ic_align.md
Name: ic_align

Overview:
Consumer end of the instruction-fetch interface for the RV32IC core; sits between IFetch and decode.
- Accepts word-aligned 32-bit fetch words and splits them into compressed (16-bit) and full (32-bit) instructions, including 32-bit instructions that straddle two words.
- Presents one aligned instruction per cycle to ID.
- Drives the fetch stall when it must drain buffered halfwords or when ID back-pressures.

Parameters:
XLEN, 32, width of PC and instruction word
RESET_PC, 32'h0, value of out_pc at reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  redirect (same cycle as fetch jmp); discards buffered state
flush_pc  input  32  redirect target; bit 0 always 0, bit 1 may be 1
fetch_valid  input  1  fetch word valid
fetch_pc  input  32  word address of fetch_instr (bits [1:0]=0)
fetch_instr  input  32  fetched word; low halfword at fetch_pc, high at fetch_pc+2
fetch_stall  output  1  to IFetch stall: hold PC and re-present the same word
id_stall  input  1  ID cannot accept; hold outputs
out_valid  output  1  aligned instruction valid
out_pc  output  32  byte address of instruction
out_instr  output  32  instruction; compressed ones zero-extended in [15:0]
out_compressed  output  1  out_instr is 16-bit

Behaviour:
- Reset (async): state=EMPTY, buffer=0, out_valid=0, out_pc=RESET_PC, out_instr=0, out_compressed=0.
- Word consumption: a word is consumed in a cycle iff fetch_valid && !fetch_stall && !flush.
- Halfword classification: compressed iff bits[1:0] != 2'b11.
- fetch_stall is combinational: id_stall || (state==HAVE_C); forced 0 while flush=1.
- Output register:
  - Loaded on posedge when !id_stall. Latency 1 cycle from consumption, or from the HAVE_C drain.
  - When id_stall=1: all outputs and state hold; no word is consumed.
- States and transitions (evaluated only when !id_stall):
  - EMPTY, word consumed:
    - lo compressed: emit lo @fetch_pc. Buffer hi with pc=fetch_pc+2; go HAVE_C if hi is compressed, else HAVE_LO32.
    - lo not compressed: emit full word @fetch_pc; stay EMPTY.
  - SKIP_LO, word consumed: discard lo.
    - hi compressed: emit hi @fetch_pc+2; go EMPTY.
    - hi not compressed: buffer hi; go HAVE_LO32; no output.
  - HAVE_C: emit buffered halfword @buf_pc; no word consumed (fetch_stall=1); go EMPTY.
  - HAVE_LO32, word consumed: emit {fetch_instr[15:0], buf} @buf_pc. Then treat fetch hi exactly as in EMPTY's lo-compressed case (HAVE_C or HAVE_LO32).
  - Any state, no word consumed and nothing to emit: out_valid=0 next cycle; state holds.
- Flush (priority over everything except reset):
  - Next cycle out_valid=0 and buffer cleared.
  - state = flush_pc[1] ? SKIP_LO : EMPTY.
- Arithmetic: pc+2 is modulo 2^32. Wrap from 32'hFFFFFFFE to 0 must not corrupt state.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
IC_ALIGN_ILLEGAL_EN
- Defined:
  - Adds output port out_illegal (1 bit, reset 0).
  - Asserted alongside out_valid when the emitted instruction is compressed and equals 16'h0000 (defined-illegal RVC encoding).
  - Registered with the other outputs.
- Undefined: port absent; 16'h0000 is passed as an ordinary compressed instruction.

Decomposition:
- Package ic_align_pkg holds:
  - state enum {EMPTY, SKIP_LO, HAVE_C, HAVE_LO32} (2 bits)
  - function is_rvc(logic [15:0])
  - constant RVC_ILLEGAL = 16'h0000
- No sub-module; one FSM plus output register. Classification is a package function.

Test Plan:
- Pure 32-bit: words 0x00100093 @0, 0x00200113 @4 → out 0x00100093 @0 then 0x00200113 @4, out_compressed=0, fetch_stall never high.
- Double compressed: word 0x00010001 @0 → out 0x0001 @0 (C=1), then fetch_stall=1 for one cycle, out 0x0001 @2; next word consumed after.
- Straddle: 0x00930001 @0, then 0xXXXX0010 @4 → out 0x0001 @0, out 0x00100093 @2, hi of second word buffered with pc 6.
- Halfword redirect: flush=1, flush_pc=0x102, then word 0x00050001 @0x100 → lo discarded, out 0x0005 @0x102, C=1.
- Back-pressure: id_stall=1 for 3 cycles mid-stream → outputs and state frozen, fetch_stall=1; on release, sequence resumes with no lost or duplicated instruction.
- Async reset asserted in HAVE_LO32 between clock edges → out_valid=0, out_pc=RESET_PC immediately; first post-reset word treated from EMPTY.
